pts_tx_sched: RTL and testbench
===============================

# pts_tx_sched

Transmit scheduler that shares one parallel-to-serial shift register (NUM_BITS wide, idle-high serial line) between two word requesters. It arbitrates round-robin, captures the winning word, and drives `load_enable`/`shift_enable`/`parallel_in` of the shared shift register so that each bit is held for CLKS_PER_BIT clocks. It reports completion to the MCU serial link logic. It sits between the MCU's word producers and the shift register and owns all of that register's control inputs.

## Interface
- NUM_BITS, 8: word width; must match the shift register; ≥2
- CLKS_PER_BIT, 4: clocks each serial bit is held; ≥1
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- req  in  2  req[i] high = requester i has a word pending; level, held until ack[i]
- data0  in  NUM_BITS  requester 0 word; stable while req[0] high
- data1  in  NUM_BITS  requester 1 word; stable while req[1] high
- ack  out  2  one-cycle pulse: word of requester i captured; it may drop or change req/data
- load_enable  out  1  to shift register; one-cycle pulse per frame
- shift_enable  out  1  to shift register; one-cycle pulse per bit period
- parallel_out  out  NUM_BITS  to shift register parallel_in; captured word
- busy  out  1  high from LOAD through DONE inclusive
- done  out  1  one-cycle pulse after the last shift
- owner  out  1  requester id of the current or most recent frame

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs decode from registered state/counters only. There is no combinational path from `req`/`data` to any output.
- **IDLE.** `req` is sampled only here. If any request is set, the block picks a winner and on that edge:
  - hold ← data of the winner
  - owner ← winner
  - ack[winner] registered high
  - state → LOAD
- **Arbitration:** a single requester wins outright. With both requesting, the winner is the one ≠ `last_owner`. `last_owner` resets to 1, so requester 0 wins the first tie.
- **LOAD** (1 cycle):
  - load_enable = 1, ack[owner] = 1
  - clk_cnt ← 0, bit_cnt ← 0
  - state → SHIFT
- **SHIFT:**
  - clk_cnt increments every cycle.
  - When clk_cnt == CLKS_PER_BIT-1: shift_enable = 1 that cycle, clk_cnt ← 0, bit_cnt ← bit_cnt+1.
  - The shift with bit_cnt == NUM_BITS-1 is the last; state → DONE.
  - NUM_BITS shifts in total. The final shift leaves the line at idle '1'.
- **DONE** (1 cycle): done = 1, last_owner ← owner, state → IDLE.
- **Widths:** clk_cnt is max(1, $clog2(CLKS_PER_BIT)) bits. bit_cnt is $clog2(NUM_BITS) bits. Neither counter wraps outside SHIFT.
- `parallel_out` holds the captured word until the next capture. It is never driven from `data*` directly.
- `req` changes during LOAD/SHIFT/DONE are ignored. A `req` still high after its ack is a new request at the next IDLE.
- **Reset** (any time, including mid-frame): state → IDLE immediately, abandoning the frame with no done pulse. The shift register shares `n_rst`, so the line goes to '1'.
- **Reset values:** load_enable 0, shift_enable 0, ack 00, busy 0, done 0, owner 0, parallel_out all ones, last_owner 1.

## Timing
- Frame = 1 accept edge + 1 LOAD + NUM_BITS×CLKS_PER_BIT SHIFT + 1 DONE cycles.
- Default parameters: 34 busy cycles.
- First bit appears on the serial line after the LOAD cycle. Each bit then lasts exactly CLKS_PER_BIT cycles.
- shift_enable pulses are spaced exactly CLKS_PER_BIT cycles apart. The first occurs CLKS_PER_BIT cycles after LOAD.
- ack and load_enable are coincident, 1 cycle after the accepting edge.
- Back-to-back frames: exactly 2 cycles (DONE, IDLE) between the last shift_enable and the next load_enable.

## Test plan
- **Single word:** req[0]=1, data0=8'hA5, defaults, with an MSB-first shift register attached.
  - ack=01 and load_enable for 1 cycle.
  - serial line carries 1,0,1,0,0,1,0,1, 4 cycles each.
  - 8 shift pulses, then done, busy low, line = 1.
- **Tie:** req=11 with data0=8'h0F, data1=8'hF0.
  - Frames are served to owner 0, then 1.
  - Re-asserting 11 grants 0 next.
- **Continuous req[1]:** back-to-back frames, each 34 busy cycles.
  - 2-cycle gap between the last shift_enable and the next load_enable.
  - req[0] raised mid-frame wins the next slot.
- **Mid-frame reset:** pull n_rst low after the 3rd shift_enable.
  - All outputs take their reset values asynchronously, line = 1, no done pulse.
  - After release, a held req[0] is served from LOAD with a full 8-bit frame.
- **Minimum timing:** CLKS_PER_BIT=1, NUM_BITS=4, data0=4'b1001.
  - shift_enable high for 4 consecutive cycles.
  - Serial line reads 1,0,0,1.
  - busy lasts 6 cycles.

Source files
------------

// File: rtl/pts_tx_sched.sv
// pts_tx_sched: round-robin scheduler that feeds two word requesters through one
// shared, idle-high parallel-to-serial shift register, holding each bit CLKS_PER_BIT clocks.
module pts_tx_sched #(
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [1:0]          req,
    input  logic [NUM_BITS-1:0] data0,
    input  logic [NUM_BITS-1:0] data1,
    output logic [1:0]          ack,
    output logic                load_enable,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                busy,
    output logic                done,
    output logic                owner
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       clk_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [NUM_BITS-1:0] hold;
    logic                owner_q;
    logic                last_owner;
    logic                winner;
    logic                bit_end;

    // A lone requester wins outright; on a tie the one that did not go last wins.
    assign winner  = (&req) ? ~last_owner : req[1];
    assign bit_end = (clk_cnt == CLK_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        done         = 1'b0;
        ack          = 2'b00;
        busy         = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_enable = 1'b1;
                ack         = owner_q ? 2'b10 : 2'b01;
                state_next  = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_enable = bit_end;
                if (bit_end && (bit_cnt == BIT_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold       <= '1;
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        hold    <= winner ? data1 : data0;
                        owner_q <= winner;
                    end
                end
                ST_LOAD: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    last_owner <= owner_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign parallel_out = hold;
    assign owner        = owner_q;

endmodule

// File: tb/tb_pts_tx_sched.sv
// Bench for pts_tx_sched: vector table of arbitration frames, directed corner sequences,
// and a randomized run checked each cycle against a frame-timeline reference model.
`timescale 1ns/1ps
module tb_pts_tx_sched;
    localparam int NB  = 8;
    localparam int CPB = 4;
    localparam int S   = NB * CPB;

    logic          clk   = 1'b0;
    logic          n_rst = 1'b0;
    logic [1:0]    req   = '0;
    logic [NB-1:0] data0 = '0;
    logic [NB-1:0] data1 = '0;
    logic [1:0]    ack;
    logic          load_enable, shift_enable, busy, done, owner;
    logic [NB-1:0] parallel_out;

    logic [1:0]    req_m   = '0;
    logic [3:0]    data0_m = '0;
    logic [3:0]    data1_m = '0;
    logic [1:0]    ack_m;
    logic          load_m, shift_m, busy_m, done_m, owner_m;
    logic [3:0]    pout_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pts_tx_sched #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .n_rst(n_rst), .req(req), .data0(data0), .data1(data1),
        .ack(ack), .load_enable(load_enable), .shift_enable(shift_enable),
        .parallel_out(parallel_out), .busy(busy), .done(done), .owner(owner)
    );

    pts_tx_sched #(.NUM_BITS(4), .CLKS_PER_BIT(1)) u_min (
        .clk(clk), .n_rst(n_rst), .req(req_m), .data0(data0_m), .data1(data1_m),
        .ack(ack_m), .load_enable(load_m), .shift_enable(shift_m),
        .parallel_out(pout_m), .busy(busy_m), .done(done_m), .owner(owner_m)
    );

    // Attached MSB-first shift registers, idle high, sharing n_rst
    logic [NB-1:0] sr;
    logic [3:0]    sr_m;
    logic          line, line_m;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr   <= '1;
            sr_m <= '1;
        end else begin
            if (load_enable)       sr <= parallel_out;
            else if (shift_enable) sr <= {sr[NB-2:0], 1'b1};
            if (load_m)            sr_m <= pout_m;
            else if (shift_m)      sr_m <= {sr_m[2:0], 1'b1};
        end
    end
    assign line   = sr[NB-1];
    assign line_m = sr_m[3];

    // Reference model: position in the frame timeline (0 idle, 1 load, 2..S+1 shift, S+2 done)
    int            m_t;
    logic          m_owner, m_last;
    logic [NB-1:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_owner = 1'b0; m_last = 1'b1; m_word = '1;
    endtask

    task automatic sample();
        logic exp_line, exp_se;
        @(negedge clk);
        exp_line = 1'b1;
        exp_se   = 1'b0;
        if (m_t >= 2 && m_t <= S + 1) begin
            exp_line = m_word[NB - 1 - (m_t - 2) / CPB];
            exp_se   = ((m_t - 2) % CPB) == CPB - 1;
        end
        chk("busy", busy, m_t != 0);
        chk("load_enable", load_enable, m_t == 1);
        chk("ack", ack, (m_t == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
        chk("shift_enable", shift_enable, exp_se);
        chk("done", done, m_t == S + 2);
        chk("owner", owner, m_owner);
        chk("parallel_out", parallel_out, m_word);
        chk("line", line, exp_line);
    endtask

    task automatic advance();
        logic w;
        @(posedge clk);
        if (m_t == 0) begin
            if (req != 2'b00) begin
                w       = (req == 2'b11) ? ~m_last : req[1];
                m_owner = w;
                m_word  = w ? data1 : data0;
                m_t     = 1;
            end
        end else if (m_t == S + 2) begin
            m_last = m_owner;
            m_t    = 0;
        end else begin
            m_t++;
        end
        #1;
    endtask

    // Runs one frame from IDLE with req/data already applied
    task automatic run_frame(input string tag, input logic exp_own, input logic [NB-1:0] exp_word,
                             input bit drop);
        int            busy_n, nbits;
        logic [NB-1:0] bits;
        bit            seen_done;
        sample();
        advance();
        sample();
        chk({tag, " ack"}, ack, exp_own ? 2'b10 : 2'b01);
        chk({tag, " load_enable"}, load_enable, 1'b1);
        chk({tag, " owner"}, owner, exp_own);
        chk({tag, " word"}, parallel_out, exp_word);
        busy_n = busy ? 1 : 0;
        nbits = 0; bits = '0; seen_done = 1'b0;
        advance();
        if (drop) req = 2'b00;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            sample();
            if (busy) busy_n++;
            if (shift_enable) begin
                bits = {bits[NB-2:0], line};
                nbits++;
            end
            if (done) begin
                seen_done = 1'b1;
                chk({tag, " line idle at done"}, line, 1'b1);
            end
            advance();
        end
        chk({tag, " done seen"}, seen_done, 1'b1);
        chk({tag, " busy cycles"}, busy_n, 34);
        chk({tag, " shift count"}, nbits, NB);
        chk({tag, " serial bits"}, bits, exp_word);
    endtask

    typedef struct packed {
        logic [1:0]    req;
        logic [NB-1:0] d0;
        logic [NB-1:0] d1;
        logic          exp_own;
        logic [NB-1:0] exp_word;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b11, 8'h0F, 8'hF0, 1'b0, 8'h0F};
        tbl[1] = '{2'b11, 8'h0F, 8'hF0, 1'b1, 8'hF0};
        tbl[2] = '{2'b11, 8'h0F, 8'hF0, 1'b0, 8'h0F};
        tbl[3] = '{2'b01, 8'hA5, 8'h00, 1'b0, 8'hA5};
        tbl[4] = '{2'b10, 8'h11, 8'h3C, 1'b1, 8'h3C};
        tbl[5] = '{2'b11, 8'h81, 8'h7E, 1'b0, 8'h81};
        tbl[6] = '{2'b11, 8'h81, 8'h7E, 1'b1, 8'h7E};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ack", ack, 2'b00);
        chk("reset load_enable", load_enable, 1'b0);
        chk("reset shift_enable", shift_enable, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset owner", owner, 1'b0);
        chk("reset parallel_out", parallel_out, 8'hFF);
        chk("reset line", line, 1'b1);
        chk("reset min parallel_out", pout_m, 4'hF);
        @(posedge clk);
        #1 n_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            req = tbl[i].req; data0 = tbl[i].d0; data1 = tbl[i].d1;
            run_frame($sformatf("vec%0d", i), tbl[i].exp_own, tbl[i].exp_word, 1'b1);
        end

        // Continuous req[1]; req[0] raised mid-frame takes the following slot
        begin
            int  last_se, run, frames;
            bit  raised, drop_all;
            last_se = -1; run = 0; frames = 0; raised = 1'b0; drop_all = 1'b0;
            req = 2'b10; data1 = 8'h5A; data0 = 8'h00;
            for (int c = 0; c < 400 && frames < 4; c++) begin
                sample();
                if (busy) run++;
                if (shift_enable) last_se = c;
                if (load_enable) begin
                    if (frames > 0) chk("b2b gap", c - last_se, 3);
                    chk("b2b owner", owner, (frames == 3) ? 1'b0 : 1'b1);
                    if (frames == 3) drop_all = 1'b1;
                end
                if (done) begin
                    chk("b2b frame busy", run, 34);
                    run = 0;
                    frames++;
                end
                advance();
                if (frames == 2 && !raised && run == 10) begin
                    req = 2'b11; data0 = 8'hC3; raised = 1'b1;
                end
                if (drop_all) req = 2'b00;
            end
            chk("b2b frames completed", frames, 4);
        end

        // Reset after the third shift: abandon frame, then full frame on release
        begin
            int n_se;
            n_se = 0;
            req = 2'b01; data0 = 8'hC3;
            for (int c = 0; c < 100 && n_se < 3; c++) begin
                sample();
                if (shift_enable) n_se++;
                if (n_se < 3) advance();
            end
            chk("midrst shifts before reset", n_se, 3);
            #2 n_rst = 1'b0;
            model_reset();
            #1;
            chk("midrst ack", ack, 2'b00);
            chk("midrst load_enable", load_enable, 1'b0);
            chk("midrst shift_enable", shift_enable, 1'b0);
            chk("midrst busy", busy, 1'b0);
            chk("midrst done", done, 1'b0);
            chk("midrst owner", owner, 1'b0);
            chk("midrst parallel_out", parallel_out, 8'hFF);
            chk("midrst line", line, 1'b1);
            repeat (2) begin
                @(negedge clk);
                chk("midrst held done", done, 1'b0);
                chk("midrst held busy", busy, 1'b0);
            end
            @(posedge clk);
            #1 n_rst = 1'b1;
            run_frame("midrst recovery", 1'b0, 8'hC3, 1'b1);
        end

        // Minimum timing instance: CLKS_PER_BIT=1, NUM_BITS=4
        begin
            int         nb, bn, se_run, se_max;
            logic [3:0] bits;
            bit         fin, saw_ack, drop;
            nb = 0; bn = 0; se_run = 0; se_max = 0; bits = '0;
            fin = 1'b0; saw_ack = 1'b0; drop = 1'b0;
            req_m = 2'b01; data0_m = 4'b1001; data1_m = 4'b0110;
            for (int c = 0; c < 20 && !fin; c++) begin
                sample();
                if (busy_m) bn++;
                if (ack_m == 2'b01 && load_m) begin
                    saw_ack = 1'b1;
                    drop = 1'b1;
                end
                if (shift_m) begin
                    se_run++;
                    bits = {bits[2:0], line_m};
                    nb++;
                end else begin
                    se_run = 0;
                end
                if (se_run > se_max) se_max = se_run;
                if (done_m) fin = 1'b1;
                advance();
                if (drop) req_m = 2'b00;
            end
            chk("min ack with load", saw_ack, 1'b1);
            chk("min done seen", fin, 1'b1);
            chk("min consecutive shifts", se_max, 4);
            chk("min shift count", nb, 4);
            chk("min serial bits", bits, 4'b1001);
            chk("min busy cycles", bn, 6);
        end

        // Randomized requesters obeying the hold-until-ack protocol
        begin
            logic [1:0]    pend;
            logic [NB-1:0] rd0, rd1;
            pend = 2'b00; rd0 = '0; rd1 = '0;
            req = 2'b00;
            for (int c = 0; c < 1500; c++) begin
                sample();
                for (int i = 0; i < 2; i++) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            pend[i] = 1'b0;
                        end else if (i == 0) begin
                            rd0 = NB'($urandom);
                        end else begin
                            rd1 = NB'($urandom);
                        end
                    end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        if (i == 0) rd0 = NB'($urandom);
                        else        rd1 = NB'($urandom);
                    end
                end
                advance();
                req = pend; data0 = rd0; data1 = rd1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
